// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: multi-cycle phase sequencer sharing one memory port between fetch and load/store,
// with a bounded ready wait that halts the core on timeout.
module mem_seq_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [ADDR_W-1:0]   pc,
   input  logic                is_load,
   input  logic                is_store,
   input  logic [ADDR_W-1:0]   dmem_addr,
   input  logic [DATA_W-1:0]   dmem_wdata,
   input  logic [DATA_W/8-1:0] dmem_wstrb,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [3:0]          state,
   output logic                pc_we,
   output logic                ld_vld,
   output logic                bus_err
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_IF, S_EX, S_MEM, S_WB, S_HALT} fsm_t;

   fsm_t                r_fsm;
   logic [CW-1:0]       r_cnt;
   logic                r_ld;
   logic                r_st;
   logic                r_err;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W/8-1:0] r_wstrb;
   logic                w_if;
   logic                w_ex;
   logic                w_mem;
   logic                w_wb;
   logic                w_tmo;

   assign w_if  = r_fsm == S_IF;
   assign w_ex  = r_fsm == S_EX;
   assign w_mem = r_fsm == S_MEM;
   assign w_wb  = r_fsm == S_WB;
   assign w_tmo = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_fsm   <= S_IDLE;
         r_cnt   <= '0;
         r_ld    <= 1'b0;
         r_st    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               r_fsm <= S_IF;
               r_cnt <= '0;
            end
            S_IF, S_MEM: begin
               // ready in the final allowed cycle still completes normally
               if (mem_ready)
                  r_fsm <= w_if ? S_EX : S_WB;
               else if (w_tmo) begin
                  r_fsm <= S_HALT;
                  r_err <= 1'b1;
               end else
                  r_cnt <= r_cnt + 1'b1;
            end
            S_EX: begin
               r_ld    <= is_load & ~is_store;
               r_st    <= is_store;
               r_addr  <= dmem_addr;
               r_wdata <= dmem_wdata;
               r_wstrb <= dmem_wstrb;
               r_cnt   <= '0;
               r_fsm   <= (is_load | is_store) ? S_MEM : S_WB;
            end
            S_WB: begin
               r_fsm <= S_IF;
               r_cnt <= '0;
            end
            default: r_fsm <= S_HALT;
         endcase
      end

   assign mem_req   = w_if | w_mem;
   assign mem_we    = w_mem & r_st;
   assign mem_addr  = w_if ? pc : w_mem ? r_addr : '0;
   assign mem_wdata = (w_mem & r_st) ? r_wdata : '0;
   assign mem_wstrb = (w_mem & r_st) ? r_wstrb : '0;
   assign state     = {w_wb, w_mem, w_ex, w_if};
   assign pc_we     = w_wb;
   assign ld_vld    = w_mem & r_ld & mem_ready;
   assign bus_err   = r_err;
endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb_mem_seq_ctrl: scoreboard bench; expected memory requests are queued when the
// stimulus is set up and compared at each ready handshake.
module tb_mem_seq_ctrl;
   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] pc;
   logic        is_load;
   logic        is_store;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [3:0]  state;
   logic        pc_we;
   logic        ld_vld;
   logic        bus_err;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        ld;
   } req_t;

   req_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   mem_seq_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rstn(rstn), .pc(pc), .is_load(is_load), .is_store(is_store),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .state(state), .pc_we(pc_we),
      .ld_vld(ld_vld), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic ld);
      req_t e;
      e.we = we; e.addr = addr; e.wdata = wdata; e.strb = strb; e.ld = ld;
      sb.push_back(e);
   endtask

   // let combinational outputs settle, score any handshake, then advance one clock
   task automatic cyc();
      req_t e;
      #1;
      if (mem_req && mem_ready) begin
         if (sb.size() == 0) chk("sb_unexpected_req", 64'(mem_addr), 64'hffff_ffff);
         else begin
            e = sb.pop_front();
            chk("sb_we",    64'(mem_we),    64'(e.we));
            chk("sb_addr",  64'(mem_addr),  64'(e.addr));
            chk("sb_wdata", 64'(mem_wdata), 64'(e.wdata));
            chk("sb_wstrb", 64'(mem_wstrb), 64'(e.strb));
            chk("sb_ldvld", 64'(ld_vld),    64'(e.ld));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clr_dec();
      is_load = 0; is_store = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 0; pc = 32'h40; mem_ready = 1; clr_dec();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_state", 64'(state), 0);
      chk("rst_req", 64'(mem_req), 0);
      chk("rst_addr", 64'(mem_addr), 0);
      chk("rst_pcwe", 64'(pc_we), 0);
      chk("rst_err", 64'(bus_err), 0);
      // ALU instruction, always ready
      rstn = 1;
      push(0, 32'h40, 0, 0, 0);
      chk("idle_state", 64'(state), 0);
      cyc();
      chk("alu_if_state", 64'(state), 4'b0001);
      chk("alu_if_addr", 64'(mem_addr), 32'h40);
      chk("alu_if_pcwe", 64'(pc_we), 0);
      cyc();
      chk("alu_ex_state", 64'(state), 4'b0010);
      chk("alu_ex_req", 64'(mem_req), 0);
      cyc();
      chk("alu_wb_state", 64'(state), 4'b1000);
      chk("alu_wb_pcwe", 64'(pc_we), 1);
      pc = 32'h44;
      cyc();
      chk("alu_if2_state", 64'(state), 4'b0001);
      chk("alu_if2_pcwe", 64'(pc_we), 0);
      // fetch with three wait cycles
      push(0, 32'h44, 0, 0, 0);
      mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("wait_if_state", 64'(state), 4'b0001);
         chk("wait_if_req", 64'(mem_req), 1);
         chk("wait_if_addr", 64'(mem_addr), 32'h44);
      end
      mem_ready = 1;
      cyc();
      chk("wait_ex_state", 64'(state), 4'b0010);
      chk("wait_err", 64'(bus_err), 0);
      // load with decoder inputs scrambled during MEM
      is_load = 1; dmem_addr = 32'h100; mem_ready = 0;
      push(0, 32'h100, 0, 0, 1);
      cyc();
      chk("ld_mem_state", 64'(state), 4'b0100);
      is_load = 1'($urandom); is_store = 1'($urandom); dmem_addr = $urandom;
      dmem_wdata = $urandom; dmem_wstrb = 4'($urandom);
      #1;
      chk("ld_mem_addr", 64'(mem_addr), 32'h100);
      chk("ld_mem_we", 64'(mem_we), 0);
      chk("ld_mem_wstrb", 64'(mem_wstrb), 0);
      chk("ld_mem_ldvld_nr", 64'(ld_vld), 0);
      cyc();
      dmem_addr = $urandom; is_store = 1'($urandom); mem_ready = 1;
      cyc();
      chk("ld_wb_state", 64'(state), 4'b1000);
      clr_dec(); pc = 32'h48;
      push(0, 32'h48, 0, 0, 0);
      cyc();
      cyc();
      // store with both decode bits set
      is_load = 1; is_store = 1; dmem_addr = 32'h200; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'b0011;
      push(1, 32'h200, 32'hDEADBEEF, 4'b0011, 0);
      cyc();
      chk("st_mem_state", 64'(state), 4'b0100);
      clr_dec(); pc = 32'h4C;
      cyc();
      chk("st_wb_state", 64'(state), 4'b1000);
      push(0, 32'h4C, 0, 0, 0);
      cyc();
      cyc();
      // load that never completes: timeout
      is_load = 1; dmem_addr = 32'h300; mem_ready = 0;
      cyc();
      clr_dec();
      for (int i = 0; i < 5; i++) begin
         chk("tmo_state", 64'(state), 4'b0100);
         chk("tmo_req", 64'(mem_req), 1);
         chk("tmo_addr", 64'(mem_addr), 32'h300);
         cyc();
      end
      mem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         chk("halt_state", 64'(state), 0);
         chk("halt_req", 64'(mem_req), 0);
         chk("halt_pcwe", 64'(pc_we), 0);
         chk("halt_err", 64'(bus_err), 1);
         cyc();
      end
      // ready arriving in the last allowed cycle
      rstn = 0; pc = 32'h60;
      @(posedge clk); #1;
      chk("rst2_err", 64'(bus_err), 0);
      rstn = 1;
      push(0, 32'h60, 0, 0, 0);
      cyc();
      cyc();
      is_load = 1; dmem_addr = 32'h340; mem_ready = 0;
      push(0, 32'h340, 0, 0, 1);
      cyc();
      clr_dec();
      for (int i = 0; i < 4; i++) cyc();
      chk("late_state", 64'(state), 4'b0100);
      mem_ready = 1;
      cyc();
      chk("late_wb_state", 64'(state), 4'b1000);
      chk("late_err", 64'(bus_err), 0);
      push(0, 32'h60, 0, 0, 0);
      cyc();
      cyc();
      // reset asserted mid-store
      is_store = 1; dmem_addr = 32'h400; dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'hF; mem_ready = 0;
      cyc();
      clr_dec();
      chk("mr_state", 64'(state), 4'b0100);
      chk("mr_req", 64'(mem_req), 1);
      rstn = 0;
      #1;
      chk("mr_req_drop", 64'(mem_req), 0);
      chk("mr_state0", 64'(state), 0);
      chk("mr_we", 64'(mem_we), 0);
      chk("mr_addr", 64'(mem_addr), 0);
      chk("mr_wdata", 64'(mem_wdata), 0);
      chk("mr_wstrb", 64'(mem_wstrb), 0);
      @(posedge clk); #1;
      rstn = 1; pc = 32'h80; mem_ready = 1;
      push(0, 32'h80, 0, 0, 0);
      chk("mr_idle", 64'(state), 0);
      cyc();
      chk("mr_if_state", 64'(state), 4'b0001);
      chk("mr_if_addr", 64'(mem_addr), 32'h80);
      cyc();
      chk("mr_ex_state", 64'(state), 4'b0010);
      chk("sb_drained", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
